// File: rtl/reg_master_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reg_master_arb_pkg                                              |
// | Purpose  : Shared register-bus definitions: arbiter FSM state encoding,    |
// |            default slave timeout and the read data returned on timeout.    |
// |            Also imported by the CPU register decoder.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package reg_master_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  // Maximum number of cycles to wait for a slave ack.
  localparam int TIMEOUT_DEFAULT = 511;

  // Read data returned to a master whose read timed out.
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage
`default_nettype wire

// File: rtl/reg_master_arb_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_arb2                                                         |
// | Purpose  : Two-input round-robin grant. A lone requester always wins;      |
// |            when both request, the one not granted last wins.               |
// | Ports    : clk, reset   - clock, synchronous active-high reset             |
// |            req[1:0]     - request vector                                   |
// |            update       - strobe recording upd_idx as the last grant       |
// |            upd_idx      - master index that was just served                |
// |            any          - at least one request present                     |
// |            gnt_idx      - index of the winning master                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       upd_idx,
  output logic       any,
  output logic       gnt_idx
);

  logic last;

  // Reset value 1 makes master 0 the winner of the first collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b1;
    end else if (update) begin
      last <= upd_idx;
    end
  end

  always_comb begin
    any     = |req;
    gnt_idx = (req == 2'b11) ? ~last : req[1];
  end

endmodule
`default_nettype wire

// File: rtl/reg_master_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reg_master_arb                                                  |
// | Purpose  : Arbitrates two register-bus masters (m0 = CPU path, m1 =        |
// |            internal sequencer) onto one shared register bus, with a slave  |
// |            ack timeout and one forced idle cycle between transactions.     |
// | Ports    : clk, reset             - clock, synchronous active-high reset   |
// |            mN_req/rd_wr_L/addr/   - master N request (held until ack)      |
// |              wr_data                                                       |
// |            mN_ack, mN_rd_data     - master N 1-cycle ack and read data     |
// |            reg_req/rd_wr_L/addr/  - shared bus request (registered)        |
// |              wr_data                                                       |
// |            reg_ack, reg_rd_data   - shared bus response                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module reg_master_arb
  import reg_master_arb_pkg::*;
#(
  parameter int ADDR_W  = 25,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_rd_wr_L,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rd_data,
  input  logic              m1_req,
  input  logic              m1_rd_wr_L,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              reg_req,
  output logic              reg_rd_wr_L,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  input  logic              reg_ack,
  input  logic [DATA_W-1:0] reg_rd_data
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  arb_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic              cur;       // master currently owning the bus
  logic              arb_any;
  logic              arb_gnt;
  logic              done;
  logic [DATA_W-1:0] rsp_data;

  // A real ack beats an expiring counter in the same cycle.
  assign done     = (state == ST_BUSY) && (reg_ack || (cnt == '0));
  assign rsp_data = reg_ack     ? reg_rd_data :
                    reg_rd_wr_L ? DATA_W'(TIMEOUT_RDATA) : '0;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({m1_req, m0_req}),
    .update  (done),
    .upd_idx (cur),
    .any     (arb_any),
    .gnt_idx (arb_gnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cur         <= 1'b0;
      reg_req     <= 1'b0;
      reg_rd_wr_L <= 1'b1;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_rd_data  <= '0;
      m1_rd_data  <= '0;
    end else begin
      // Acks are single-cycle pulses; read data is zero outside the pulse.
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rd_data <= '0;
      m1_rd_data <= '0;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            cur         <= arb_gnt;
            reg_req     <= 1'b1;
            reg_rd_wr_L <= arb_gnt ? m1_rd_wr_L : m0_rd_wr_L;
            reg_addr    <= arb_gnt ? m1_addr    : m0_addr;
            reg_wr_data <= arb_gnt ? m1_wr_data : m0_wr_data;
            cnt         <= CNT_W'(TIMEOUT);
            state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (done) begin
            reg_req <= 1'b0;
            if (cur) begin
              m1_ack     <= 1'b1;
              m1_rd_data <= rsp_data;
            end else begin
              m0_ack     <= 1'b1;
              m0_rd_data <= rsp_data;
            end
            state <= ST_RELEASE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        // Requests are ignored here; the served master is still dropping req.
        ST_RELEASE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
